// File: rtl/formula_stack_ctrl.sv
// Backtracking sequencer for the DPLL core: pushes formula snapshots on decisions,
// pops/restores them on conflict, and tracks per-level decision variable and flip status.
module formula_stack_ctrl #(
  parameter int FORMULA_W = 64,
  parameter int VAR_W     = 6,
  parameter int DEPTH     = 16,
  parameter int LVL_W     = $clog2(DEPTH+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [FORMULA_W-1:0] dec_formula,
  input  logic [VAR_W-1:0]     dec_var,
  input  logic                 conflict,
  output logic                 ready,
  output logic                 stk_wr_en,
  output logic                 stk_pop,
  output logic [FORMULA_W-1:0] stk_din,
  input  logic                 stk_full,
  input  logic                 stk_empty,
  input  logic [FORMULA_W-1:0] stk_dout,
  output logic                 restore_valid,
  output logic [FORMULA_W-1:0] restore_formula,
  output logic [VAR_W-1:0]     restore_var,
  output logic                 restore_pol,
  output logic [LVL_W-1:0]     level,
  output logic                 unsat,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_POP, S_CHECK, S_RESTORE, S_UNSAT, S_ERR
  } state_t;

  state_t                      state_q, state_d;
  logic [LVL_W-1:0]            level_q, level_d;
  logic [DEPTH-1:0][VAR_W-1:0] var_mem_q, var_mem_d;
  logic [DEPTH-1:0]            flipped_q, flipped_d;
  logic [FORMULA_W-1:0]        hold_formula_q, hold_formula_d;
  logic [VAR_W-1:0]            hold_var_q, hold_var_d;
  logic [FORMULA_W-1:0]        restore_formula_q, restore_formula_d;
  logic [VAR_W-1:0]            restore_var_q, restore_var_d;
  logic                        restore_pol_q, restore_pol_d;

  logic [LVL_W-1:0]            top_lvl;
  logic                        top_flipped;
  logic [VAR_W-1:0]            top_var;

  // Top-of-search entry lives at level-1; only meaningful while level > 0.
  assign top_lvl = level_q - LVL_W'(1);

  always_comb begin
    top_flipped = 1'b0;
    top_var     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (top_lvl == LVL_W'(i)) begin
        top_flipped = flipped_q[i];
        top_var     = var_mem_q[i];
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    level_d           = level_q;
    var_mem_d         = var_mem_q;
    flipped_d         = flipped_q;
    hold_formula_d    = hold_formula_q;
    hold_var_d        = hold_var_q;
    restore_formula_d = restore_formula_q;
    restore_var_d     = restore_var_q;
    restore_pol_d     = restore_pol_q;
    unique case (state_q)
      S_IDLE: begin
        if (conflict) begin
          state_d = (level_q == '0) ? S_UNSAT : S_POP;
        end else if (dec_valid) begin
          if (level_q == LVL_W'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            hold_formula_d = dec_formula;
            hold_var_d     = dec_var;
            state_d        = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        if (stk_full) begin
          state_d = S_ERR;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LVL_W'(i)) begin
              var_mem_d[i] = hold_var_q;
              flipped_d[i] = 1'b0;
            end
          end
          level_d = level_q + LVL_W'(1);
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        state_d = stk_empty ? S_ERR : S_CHECK;
      end
      S_CHECK: begin
        hold_formula_d = stk_dout;
        if (!top_flipped) begin
          restore_formula_d = stk_dout;
          restore_var_d     = top_var;
          restore_pol_d     = 1'b1;
          state_d           = S_RESTORE;
        end else begin
          // Both polarities exhausted at this level: backtrack one more.
          for (int i = 0; i < DEPTH; i++) begin
            if (top_lvl == LVL_W'(i)) flipped_d[i] = 1'b0;
          end
          level_d = top_lvl;
          state_d = (top_lvl == '0) ? S_UNSAT : S_POP;
        end
      end
      S_RESTORE: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (top_lvl == LVL_W'(i)) flipped_d[i] = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_UNSAT: state_d = S_UNSAT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      level_q           <= '0;
      var_mem_q         <= '0;
      flipped_q         <= '0;
      hold_formula_q    <= '0;
      hold_var_q        <= '0;
      restore_formula_q <= '0;
      restore_var_q     <= '0;
      restore_pol_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      level_q           <= level_d;
      var_mem_q         <= var_mem_d;
      flipped_q         <= flipped_d;
      hold_formula_q    <= hold_formula_d;
      hold_var_q        <= hold_var_d;
      restore_formula_q <= restore_formula_d;
      restore_var_q     <= restore_var_d;
      restore_pol_q     <= restore_pol_d;
    end
  end

  assign ready           = (state_q == S_IDLE);
  assign stk_wr_en       = (state_q == S_PUSH) || (state_q == S_RESTORE);
  assign stk_pop         = (state_q == S_POP);
  assign stk_din         = hold_formula_q;
  assign restore_valid   = (state_q == S_RESTORE);
  assign restore_formula = restore_formula_q;
  assign restore_var     = restore_var_q;
  assign restore_pol     = restore_pol_q;
  assign level           = level_q;
  assign unsat           = (state_q == S_UNSAT);
  assign error           = (state_q == S_ERR);

endmodule

// File: tb/tb_formula_stack_ctrl.sv
// Randomized + directed bench for formula_stack_ctrl against a decision-tree model.
module tb_formula_stack_ctrl;
  localparam int FW = 64;
  localparam int VW = 6;
  localparam int D  = 16;
  localparam int LW = $clog2(D+1);

  logic          clock = 0, reset = 1;
  logic          dec_valid = 0, conflict = 0;
  logic [FW-1:0] dec_formula = '0;
  logic [VW-1:0] dec_var = '0;
  logic          ready, stk_wr_en, stk_pop, stk_full, stk_empty;
  logic [FW-1:0] stk_din, stk_dout, restore_formula;
  logic          restore_valid, restore_pol, unsat, error;
  logic [VW-1:0] restore_var;
  logic [LW-1:0] level;

  formula_stack_ctrl #(.FORMULA_W(FW), .VAR_W(VW), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .dec_valid(dec_valid), .dec_formula(dec_formula),
    .dec_var(dec_var), .conflict(conflict), .ready(ready), .stk_wr_en(stk_wr_en),
    .stk_pop(stk_pop), .stk_din(stk_din), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_dout(stk_dout), .restore_valid(restore_valid), .restore_formula(restore_formula),
    .restore_var(restore_var), .restore_pol(restore_pol), .level(level),
    .unsat(unsat), .error(error));

  always #5 clock = ~clock;

  // Attached formula stack (environment), with forcible status flags.
  logic          force_full = 0, force_empty = 0;
  logic [FW-1:0] mem [D];
  int            sp;
  assign stk_full  = force_full  || (sp == D);
  assign stk_empty = force_empty || (sp == 0);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sp       <= 0;
      stk_dout <= '0;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= mem[sp-1];
      sp       <= sp - 1;
    end else if (stk_wr_en && sp < D) begin
      mem[sp] <= stk_din;
      sp      <= sp + 1;
    end
  end

  // Free-running strobe monitor; tests look at deltas.
  int            n_push = 0, n_pop = 0, n_rv = 0;
  logic [FW-1:0] last_din = '0, rv_form = '0;
  logic [VW-1:0] rv_var = '0;
  logic          rv_pol = 0;
  always @(posedge clock) begin
    if (stk_wr_en) begin n_push <= n_push + 1; last_din <= stk_din; end
    if (stk_pop) n_pop <= n_pop + 1;
    if (restore_valid) begin
      n_rv <= n_rv + 1; rv_form <= restore_formula; rv_var <= restore_var; rv_pol <= restore_pol;
    end
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one entry per decision level.
  logic [FW-1:0] m_form[$];
  logic [VW-1:0] m_var[$];
  bit            m_flip[$];
  bit            m_unsat, m_err;

  task automatic do_reset();
    reset = 1; dec_valid = 0; conflict = 0; force_full = 0; force_empty = 0;
    m_form.delete(); m_var.delete(); m_flip.delete(); m_unsat = 0; m_err = 0;
    @(posedge clock); #1;
    reset = 0;
    @(posedge clock); #1;
  endtask

  task automatic op(input bit d, input bit c, input logic [FW-1:0] f, input logic [VW-1:0] v);
    int ecyc, epush, epop, erv, k, cycles, p0, q0, r0, top;
    logic [FW-1:0] ef;
    logic [VW-1:0] ev;
    bit dec_ok;
    ecyc = 1; epush = 0; epop = 0; erv = 0; k = 0; dec_ok = 0; ef = '0; ev = '0;
    if (!(m_unsat || m_err)) begin
      if (c) begin
        if (m_form.size() == 0) m_unsat = 1;
        else if (force_empty) begin m_err = 1; ecyc = 2; epop = 1; end
        else begin
          while (m_flip.size() > 0 && m_flip[m_flip.size()-1]) begin
            void'(m_form.pop_back()); void'(m_var.pop_back()); void'(m_flip.pop_back());
            k++;
          end
          if (m_flip.size() == 0) begin
            m_unsat = 1; epop = k; ecyc = 2*k + 1;
          end else begin
            top = m_flip.size() - 1;
            m_flip[top] = 1; ef = m_form[top]; ev = m_var[top];
            epop = k + 1; epush = 1; erv = 1; ecyc = 4 + 2*k;
          end
        end
      end else if (d) begin
        if (m_form.size() == D) m_err = 1;
        else if (force_full) begin m_err = 1; ecyc = 2; epush = 1; end
        else begin
          m_form.push_back(f); m_var.push_back(v); m_flip.push_back(0);
          ecyc = 2; epush = 1; dec_ok = 1;
        end
      end
    end
    p0 = n_push; q0 = n_pop; r0 = n_rv;
    dec_valid = d; conflict = c; dec_formula = f; dec_var = v;
    @(posedge clock); #1;
    dec_valid = 0; conflict = 0;
    cycles = 1;
    while (!ready && !unsat && !error && cycles < 200) begin
      @(posedge clock); #1;
      cycles++;
    end
    chk("cycles", cycles, ecyc);
    chk("level", level, m_form.size());
    chk("unsat", unsat, m_unsat);
    chk("error", error, m_err);
    chk("ready", ready, !(m_unsat || m_err));
    chk("pushes", n_push - p0, epush);
    chk("pops", n_pop - q0, epop);
    chk("restores", n_rv - r0, erv);
    if (erv) begin
      chk("rst_var", rv_var, ev);
      chk("rst_form", rv_form, ef);
      chk("rst_pol", rv_pol, 1);
    end
    if (dec_ok) chk("push_din", last_din, f);
  endtask

  function automatic logic [FW-1:0] rnd_f();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [FW-1:0] f1, f2;
    f1 = 64'h1111_2222_3333_4444;
    f2 = 64'hAAAA_BBBB_CCCC_DDDD;
    do_reset();
    chk("rst_ready", ready, 1); chk("rst_level", level, 0);
    chk("rst_unsat", unsat, 0); chk("rst_error", error, 0);
    chk("rst_wr", stk_wr_en, 0); chk("rst_pop", stk_pop, 0);
    chk("rst_rv", restore_valid, 0); chk("rst_din", stk_din, 0);
    chk("rst_rform", restore_formula, 0); chk("rst_rvar", restore_var, 0);
    chk("rst_rpol", restore_pol, 0);

    // Directed walk through the backtracking tree.
    op(1, 0, f1, 6'd3);
    op(1, 0, f2, 6'd5);
    op(0, 1, '0, '0);
    op(0, 1, '0, '0);
    op(0, 1, '0, '0);
    op(1, 0, rnd_f(), 6'd9);

    do_reset();
    op(0, 1, '0, '0);
    op(1, 0, f1, 6'd1);

    do_reset();
    for (int i = 0; i < D; i++) op(1, 0, rnd_f(), VW'(i));
    op(1, 0, f1, 6'd2);

    do_reset();
    op(1, 0, f1, 6'd7);
    force_empty = 1;
    op(0, 1, '0, '0);
    force_empty = 0;
    op(1, 0, f2, 6'd8);

    do_reset();
    force_full = 1;
    op(1, 0, f1, 6'd4);
    force_full = 0;

    // Conflict wins over a simultaneous decision, then async reset lands in CHECK.
    do_reset();
    op(1, 0, f1, 6'd3);
    op(1, 1, f2, 6'd5);
    op(1, 0, f2, 6'd6);
    conflict = 1;
    @(posedge clock); #1; conflict = 0;
    chk("pop_state", stk_pop, 1);
    @(posedge clock); #1;
    reset = 1;
    #1;
    chk("arst_ready", ready, 1); chk("arst_level", level, 0);
    chk("arst_pop", stk_pop, 0); chk("arst_wr", stk_wr_en, 0);
    chk("arst_rv", restore_valid, 0); chk("arst_rform", restore_formula, 0);
    chk("arst_rvar", restore_var, 0); chk("arst_rpol", restore_pol, 0);
    chk("arst_din", stk_din, 0);
    do_reset();

    // Random episodes.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int n = 0; n < 60 && !m_unsat; n++) begin
        int r;
        r = $urandom_range(99);
        if (m_form.size() == D || (m_form.size() > 0 && r < 35) || r < 3)
          op(r[0], 1, rnd_f(), VW'($urandom()));
        else
          op(1, 0, rnd_f(), VW'($urandom()));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
